instr_align_buffer: RTL and testbench



---
 rtl/instr_align_buffer_if.sv | 27 ++
 rtl/instr_align_buffer.sv | 134 +++++++++++++
 tb/tb_instr_align_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_align_buffer_if.sv
// Fetch-side and decode-side signal bundle of the instruction realignment buffer.
// Handshake: a fetch block moves on fetch_valid & fetch_ready; issue lanes move on issue_ready & issue_valid[0], taking every valid lane at once.
interface instr_align_buffer_if #(
  parameter int FETCH_W = 64,
  parameter int ISSUE_N = 2
);
  logic                   flush;
  logic [63:0]            flush_pc;
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [FETCH_W-1:0]     fetch_data;
  logic [ISSUE_N-1:0]     issue_valid;
  logic [32*ISSUE_N-1:0]  issue_instr;
  logic [64*ISSUE_N-1:0]  issue_pc;
  logic [ISSUE_N-1:0]     issue_is_rvc;
  logic                   issue_ready;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, issue_ready,
    input  fetch_ready, issue_valid, issue_instr, issue_pc, issue_is_rvc
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, issue_ready,
    output fetch_ready, issue_valid, issue_instr, issue_pc, issue_is_rvc
  );
endinterface

// File: rtl/instr_align_buffer.sv
// Fetch-to-decode realignment buffer: circular halfword queue presenting up to ISSUE_N aligned instructions.
// Optional feature: define RIFT_RVC_EN to align mixed 16/32-bit instructions; otherwise every instruction is 32 bits.
module instr_align_buffer #(
  parameter int FETCH_W = 64,
  parameter int BUF_HW  = 16,
  parameter int ISSUE_N = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  instr_align_buffer_if.slave  bus
);
  localparam int BLK_HW = FETCH_W / 16;
  localparam int PTR_W  = $clog2(BUF_HW);
  localparam int CNT_W  = PTR_W + 1;
`ifdef RIFT_RVC_EN
  localparam logic [63:0] PC_MASK = ~64'd1;
`else
  localparam logic [63:0] PC_MASK = ~64'd3;
`endif

  logic [15:0]           mem_q [BUF_HW];
  logic [15:0]           mem_d [BUF_HW];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [63:0]           head_pc_q, head_pc_d;

  logic                  fetch_ready;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      pop_hw;
  logic [ISSUE_N-1:0]    lane_valid;
  logic [ISSUE_N-1:0]    lane_rvc;
  logic [32*ISSUE_N-1:0] lane_instr;
  logic [64*ISSUE_N-1:0] lane_pc;

  // Lane walk temporaries
  logic [CNT_W-1:0]      off;
  logic [CNT_W-1:0]      len;
  logic [PTR_W-1:0]      start;
  logic [15:0]           hw_lo;
  logic [15:0]           hw_hi;
  logic                  is_rvc;
  logic                  chain;

  // Space freed by a same-cycle pop is deliberately not credited here.
  assign fetch_ready = (count_q <= CNT_W'(BUF_HW - BLK_HW));

  always_comb begin
    lane_valid = '0;
    lane_rvc   = '0;
    lane_instr = '0;
    lane_pc    = '0;
    off        = '0;
    len        = '0;
    start      = '0;
    hw_lo      = '0;
    hw_hi      = '0;
    is_rvc     = 1'b0;
    chain      = 1'b1;
    for (int i = 0; i < ISSUE_N; i++) begin
      start = head_q + off[PTR_W-1:0];
      hw_lo = mem_q[start];
      hw_hi = mem_q[start + PTR_W'(1)];
`ifdef RIFT_RVC_EN
      is_rvc = (hw_lo[1:0] != 2'b11);
`else
      is_rvc = 1'b0;
`endif
      len = is_rvc ? CNT_W'(1) : CNT_W'(2);
      // A lane is only offered once every one of its halfwords is buffered.
      if (chain && ((off + len) <= count_q)) begin
        lane_valid[i]          = 1'b1;
        lane_rvc[i]            = is_rvc;
        lane_instr[32*i +: 32] = is_rvc ? {16'h0000, hw_lo} : {hw_hi, hw_lo};
        lane_pc[64*i +: 64]    = head_pc_q + {{(63-CNT_W){1'b0}}, off, 1'b0};
        off                    = off + len;
      end else begin
        chain = 1'b0;
      end
    end
    pop_hw = off;
  end

  always_comb begin
    push      = bus.fetch_valid && fetch_ready;
    pop       = bus.issue_ready && lane_valid[0];
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    if (bus.flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      head_pc_d = bus.flush_pc & PC_MASK;
    end else begin
      if (push) begin
        for (int k = 0; k < BLK_HW; k++) begin
          mem_d[tail_q + PTR_W'(k)] = bus.fetch_data[16*k +: 16];
        end
        tail_d = tail_q + PTR_W'(BLK_HW);
      end
      if (pop) begin
        head_d    = head_q + pop_hw[PTR_W-1:0];
        head_pc_d = head_pc_q + {{(63-CNT_W){1'b0}}, pop_hw, 1'b0};
      end
      count_d = count_q + (push ? CNT_W'(BLK_HW) : '0) - (pop ? pop_hw : '0);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem_q     <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

  assign bus.fetch_ready  = fetch_ready;
  assign bus.issue_valid  = lane_valid;
  assign bus.issue_instr  = lane_instr;
  assign bus.issue_pc     = lane_pc;
  assign bus.issue_is_rvc = lane_rvc;
endmodule

// File: tb/tb_instr_align_buffer.sv
// Bench for instr_align_buffer: halfword-queue reference model plus an instruction-order scoreboard.
module tb_instr_align_buffer;
  localparam int FETCH_W = 64;
  localparam int BUF_HW  = 16;
  localparam int ISSUE_N = 2;
  localparam int BLK_HW  = FETCH_W / 16;
  localparam int BW      = ISSUE_N * 98 + 1;
`ifdef RIFT_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic CLK;
  logic RSTn;
  instr_align_buffer_if #(.FETCH_W(FETCH_W), .ISSUE_N(ISSUE_N)) bus ();

  instr_align_buffer #(.FETCH_W(FETCH_W), .BUF_HW(BUF_HW), .ISSUE_N(ISSUE_N)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [15:0]   hw_q[$];
  logic [15:0]   stream_q[$];
  logic [31:0]   exp_q[$];
  logic [63:0]   m_head_pc;
  logic [BW-1:0] got_v, exp_v;
  localparam logic [BW-1:0] RESET_V = {{(BW-1){1'b0}}, 1'b1};

  // reference model: buffer is a queue of halfwords, lanes walk it from the front
  function automatic void model_lanes(output logic [ISSUE_N-1:0] ev, output logic [32*ISSUE_N-1:0] ei,
                                      output logic [64*ISSUE_N-1:0] ep, output logic [ISSUE_N-1:0] er,
                                      output int ph);
    int pos;
    int n;
    bit stop;
    bit rvc;
    logic [15:0] h0;
    ev = '0; ei = '0; ep = '0; er = '0; pos = 0; stop = 0;
    for (int l = 0; l < ISSUE_N; l++) begin
      if (!stop && pos < hw_q.size()) begin
        h0  = hw_q[pos];
        rvc = RVC && (h0[1:0] != 2'b11);
        n   = rvc ? 1 : 2;
        if (pos + n <= hw_q.size()) begin
          ev[l] = 1'b1;
          er[l] = rvc;
          if (rvc) ei[32*l +: 32] = {16'h0000, h0};
          else     ei[32*l +: 32] = {hw_q[pos+1], h0};
          ep[64*l +: 64] = m_head_pc + 64'(2 * pos);
          pos += n;
        end else stop = 1;
      end else stop = 1;
    end
    ph = pos;
  endfunction

  function automatic logic model_ready();
    return (BUF_HW - hw_q.size()) >= BLK_HW;
  endfunction

  function automatic logic [BW-1:0] exp_vec();
    logic [ISSUE_N-1:0] ev, er;
    logic [32*ISSUE_N-1:0] ei;
    logic [64*ISSUE_N-1:0] ep;
    int ph;
    model_lanes(ev, ei, ep, er, ph);
    return {ev, ei, ep, er, model_ready()};
  endfunction

  function automatic logic [BW-1:0] obs_vec();
    return {bus.issue_valid, bus.issue_instr, bus.issue_pc, bus.issue_is_rvc, bus.fetch_ready};
  endfunction

  // driver: one clock with the given inputs, then the model takes the same step
  task automatic cycle(input logic fv, input logic [FETCH_W-1:0] fd, input logic ir,
                       input logic fl, input logic [63:0] fpc, output logic pushed);
    logic [ISSUE_N-1:0] ev, er;
    logic [32*ISSUE_N-1:0] ei;
    logic [64*ISSUE_N-1:0] ep;
    int ph;
    logic rdy;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.issue_ready = ir;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    model_lanes(ev, ei, ep, er, ph);
    rdy = model_ready();
    @(posedge CLK);
    #1;
    pushed = 1'b0;
    if (fl) begin
      hw_q.delete();
      m_head_pc = fpc & (RVC ? ~64'd1 : ~64'd3);
    end else begin
      if (ir && ev[0]) begin
        for (int k = 0; k < ph; k++) void'(hw_q.pop_front());
        m_head_pc += 64'(2 * ph);
      end
      if (fv && rdy) begin
        for (int k = 0; k < BLK_HW; k++) hw_q.push_back(fd[16*k +: 16]);
        pushed = 1'b1;
      end
    end
    bus.fetch_valid = 1'b0;
    bus.issue_ready = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic gen_instr();
    logic [31:0] w;
    w = $urandom;
    if (RVC && ($urandom_range(0, 1) == 1)) begin
      w[1:0] = 2'($urandom_range(0, 2));
      stream_q.push_back(w[15:0]);
      exp_q.push_back({16'h0000, w[15:0]});
    end else begin
      if (RVC) w[1:0] = 2'b11;
      stream_q.push_back(w[15:0]);
      stream_q.push_back(w[31:16]);
      exp_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    bus.issue_ready = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    hw_q.delete();
    m_head_pc = '0;
    repeat (3) @(posedge CLK);
    #1;
    got_v = obs_vec();
    total++;
    if (got_v !== RESET_V) begin bad++; $display("FAIL reset_state: got %h want %h", got_v, RESET_V); end
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    got_v = obs_vec();
    total++;
    if (got_v !== RESET_V) begin bad++; $display("FAIL reset_release: got %h want %h", got_v, RESET_V); end
  endtask

  task automatic test_rvc_basic();
    logic p;
    cycle(1'b0, '0, 1'b0, 1'b1, 64'h8000_0000, p);
    cycle(1'b1, 64'h0041_0031_0021_0011, 1'b0, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL rvc_basic_lanes: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.issue_pc[127:64] !== (RVC ? 64'h8000_0002 : 64'h8000_0004)) begin
      bad++; $display("FAIL rvc_basic_pc1: got %h want %h", bus.issue_pc[127:64], (RVC ? 64'h8000_0002 : 64'h8000_0004));
    end
    total++;
    if (bus.issue_is_rvc !== (RVC ? 2'b11 : 2'b00)) begin
      bad++; $display("FAIL rvc_basic_isrvc: got %b want %b", bus.issue_is_rvc, (RVC ? 2'b11 : 2'b00));
    end
    cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL rvc_basic_after_pop: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.issue_pc[63:0] !== (RVC ? 64'h8000_0004 : 64'h0)) begin
      bad++; $display("FAIL rvc_basic_pc_after_pop: got %h want %h", bus.issue_pc[63:0], (RVC ? 64'h8000_0004 : 64'h0));
    end
  endtask

  task automatic test_straddle();
    logic p;
    cycle(1'b0, '0, 1'b0, 1'b1, 64'h4000, p);
    cycle(1'b1, 64'h1233_0009_0005_0001, 1'b0, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL straddle_first: got %h want %h", got_v, exp_v); end
    cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
    total++;
    if (bus.issue_valid !== (RVC ? 2'b01 : 2'b00)) begin
      bad++; $display("FAIL straddle_partial: got %b want %b", bus.issue_valid, (RVC ? 2'b01 : 2'b00));
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
      got_v = obs_vec(); exp_v = exp_vec();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL straddle_stall: got %h want %h", got_v, exp_v); end
    end
    cycle(1'b1, 64'h3333_2222_0011_ABCD, 1'b0, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL straddle_joined: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.issue_instr[31:0] !== (RVC ? 32'hABCD_1233 : 32'h0011_ABCD) || bus.issue_is_rvc[0] !== 1'b0) begin
      bad++; $display("FAIL straddle_instr: got %h want %h", bus.issue_instr[31:0], (RVC ? 32'hABCD_1233 : 32'h0011_ABCD));
    end
  endtask

  task automatic test_fill();
    logic p;
    logic [FETCH_W-1:0] blk;
    cycle(1'b0, '0, 1'b0, 1'b1, 64'h2000, p);
    for (int b = 0; b < 5; b++) begin
      blk = {$urandom, $urandom};
      blk[1:0]   = 2'b11;
      blk[33:32] = 2'b11;
      cycle(1'b1, blk, 1'b0, 1'b0, '0, p);
      got_v = obs_vec(); exp_v = exp_vec();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL fill_block%0d: got %h want %h", b, got_v, exp_v); end
    end
    total++;
    if (bus.fetch_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %b want 0", bus.fetch_ready); end
    cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL fill_pop: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.fetch_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop: got %b want 1", bus.fetch_ready); end
  endtask

  task automatic test_back_to_back();
    logic p;
    logic fv, ir;
    logic have;
    logic [FETCH_W-1:0] blk;
    logic [63:0] last_pc;
    int issued;
    cycle(1'b0, '0, 1'b0, 1'b1, 64'h100, p);
    stream_q.delete();
    exp_q.delete();
    have = 1'b0; last_pc = '0; issued = 0; blk = '0;
    for (int c = 0; c < 60; c++) begin
      fv = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ir = (c < 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (!have) begin
        while (stream_q.size() < BLK_HW) gen_instr();
        for (int k = 0; k < BLK_HW; k++) blk[16*k +: 16] = stream_q.pop_front();
        have = 1'b1;
      end
      got_v = obs_vec(); exp_v = exp_vec();
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL stream_lanes c=%0d: got %h want %h", c, got_v, exp_v); end
      if (ir && bus.issue_valid[0]) begin
        for (int l = 0; l < ISSUE_N; l++) begin
          if (bus.issue_valid[l]) begin
            total++;
            if (exp_q.size() == 0 || bus.issue_instr[32*l +: 32] !== exp_q[0] || bus.issue_pc[64*l +: 64] <= last_pc) begin
              bad++;
              $display("FAIL stream_order c=%0d lane=%0d: got %h pc %h want %h after pc %h", c, l,
                       bus.issue_instr[32*l +: 32], bus.issue_pc[64*l +: 64], (exp_q.size() != 0) ? exp_q[0] : 32'hx, last_pc);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            last_pc = bus.issue_pc[64*l +: 64];
            issued++;
          end
        end
      end
      cycle(fv, blk, ir, 1'b0, '0, p);
      if (p) have = 1'b0;
    end
    total++;
    if (issued < 20) begin bad++; $display("FAIL stream_count: got %0d want at least 20", issued); end
  endtask

  task automatic test_flush();
    logic p;
    cycle(1'b1, 64'h0007_0003_0002_0001, 1'b0, 1'b0, '0, p);
    cycle(1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b1, 64'h1003, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL flush_state: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.issue_valid !== '0) begin bad++; $display("FAIL flush_valid: got %b want 00", bus.issue_valid); end
    cycle(1'b1, 64'hBBBB_AAA3_0009_0005, 1'b0, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL flush_refill: got %h want %h", got_v, exp_v); end
    total++;
    if (bus.issue_pc[63:0] !== (RVC ? 64'h1002 : 64'h1000)) begin
      bad++; $display("FAIL flush_head_pc: got %h want %h", bus.issue_pc[63:0], (RVC ? 64'h1002 : 64'h1000));
    end
  endtask

  task automatic test_reset_mid();
    logic p;
    cycle(1'b0, '0, 1'b0, 1'b1, 64'h3000, p);
    cycle(1'b1, 64'h2222_1113_0005_0001, 1'b0, 1'b0, '0, p);
    cycle(1'b1, 64'h4444_3333_2222_1113, 1'b0, 1'b0, '0, p);
    cycle(1'b1, 64'h6666_5553_4444_3333, 1'b0, 1'b0, '0, p);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL reset_mid_before: got %h want %h", got_v, exp_v); end
    #2;
    RSTn = 1'b0;
    #1;
    hw_q.delete();
    m_head_pc = '0;
    got_v = obs_vec();
    total++;
    if (got_v !== RESET_V) begin bad++; $display("FAIL reset_mid_async: got %h want %h", got_v, RESET_V); end
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0, '0, p);
    got_v = obs_vec(); exp_v = exp_vec();
    total++;
    if (got_v !== exp_v) begin bad++; $display("FAIL reset_mid_after: got %h want %h", got_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_rvc_basic();
    test_straddle();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
